// File: rtl/sign_ext_pipe_if.sv
// Producer/consumer bundle for sign_ext_pipe: immediate in, extended result out.
interface sign_ext_pipe_if #(
   parameter int IN_SIZE  = 16,
   parameter int OUT_SIZE = 32
);
   logic [IN_SIZE-1:0]  in;
   logic [1:0]          mode;
   logic                in_valid;
   logic                in_ready;
   logic [OUT_SIZE-1:0] out;
   logic                out_valid;
   logic                out_ready;
   logic [1:0]          count;

   // Environment side: drives the immediate and consumes results.
   modport master (
      output in, mode, in_valid, out_ready,
      input  in_ready, out, out_valid, count
   );

   // Block side.
   modport slave (
      input  in, mode, in_valid, out_ready,
      output in_ready, out, out_valid, count
   );
endinterface

// File: rtl/sign_ext_pipe.sv
// Immediate extender (zero/sign/branch-offset/upper) feeding a 2-entry result FIFO.
module sign_ext_pipe #(
   parameter int IN_SIZE  = 16,
   parameter int OUT_SIZE = 32,
   parameter int SHAMT    = 2
) (
   input logic            clk,
   input logic            rst,
   sign_ext_pipe_if.slave bus
);

   logic [OUT_SIZE-1:0]      zext, sext, res;
   logic [1:0][OUT_SIZE-1:0] mem;
   logic                     rd_ptr, wr_ptr;
   logic [1:0]               count;
   logic                     push, pop;

   // Extension result; shifts keep the IN_SIZE == OUT_SIZE case free of zero-width fields.
   always_comb begin
      zext = OUT_SIZE'(bus.in);
      sext = OUT_SIZE'($signed(bus.in));
      res  = zext;
      case (bus.mode)
         2'd0:    res = zext;
         2'd1:    res = sext;
         2'd2:    res = sext << SHAMT;
         default: res = zext << (OUT_SIZE - IN_SIZE);
      endcase
   end

   // in_ready is pure state plus reset: a pop in the full cycle does not open a slot.
   assign bus.in_ready  = !rst && (count != 2'd2);
   assign bus.out_valid = (count != 2'd0);
   assign bus.out       = mem[rd_ptr];
   assign bus.count     = count;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   // FIFO state: reset clears storage so out reads zero while empty after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem    <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= res;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_sign_ext_pipe.sv
// Bench for sign_ext_pipe: vector table, directed FIFO corner cases, random traffic vs queue model.
module tb_sign_ext_pipe;
   localparam int IN  = 2;
   localparam int OUT = 4;
   localparam int SH  = 1;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sign_ext_pipe_if #(.IN_SIZE(IN), .OUT_SIZE(OUT)) bus ();

   sign_ext_pipe #(.IN_SIZE(IN), .OUT_SIZE(OUT), .SHAMT(SH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [IN-1:0]  in;
      logic [1:0]     mode;
      logic [OUT-1:0] exp;
   } vec_t;

   vec_t tv[16];
   logic [OUT-1:0] q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [IN-1:0] i, input logic [1:0] m, input logic ordy);
      bus.in_valid  = v;
      bus.in        = i;
      bus.mode      = m;
      bus.out_ready = ordy;
   endtask

   // Reference extension from plain integer arithmetic on the mode rules.
   function automatic logic [OUT-1:0] model(input int unsigned v, input int unsigned m);
      longint md, sv, r;
      md = longint'(1) << OUT;
      sv = (v >= (1 << (IN - 1))) ? longint'(v) - (longint'(1) << IN) : longint'(v);
      case (m)
         0:       r = longint'(v);
         1:       r = sv;
         2:       r = sv * (longint'(1) << SH);
         default: r = longint'(v) * (longint'(1) << (OUT - IN));
      endcase
      r = ((r % md) + md) % md;
      return r[OUT-1:0];
   endfunction

   initial begin
      logic           ivld, ordy, push, pop, stalled;
      logic [IN-1:0]  rin;
      logic [1:0]     rmode;
      logic [OUT-1:0] prev_out, exp_v;

      // hand-derived table for IN=2, OUT=4, SHAMT=1
      tv[0]  = '{2'b00, 2'd0, 4'b0000}; tv[1]  = '{2'b00, 2'd1, 4'b0000};
      tv[2]  = '{2'b00, 2'd2, 4'b0000}; tv[3]  = '{2'b00, 2'd3, 4'b0000};
      tv[4]  = '{2'b01, 2'd0, 4'b0001}; tv[5]  = '{2'b01, 2'd1, 4'b0001};
      tv[6]  = '{2'b01, 2'd2, 4'b0010}; tv[7]  = '{2'b01, 2'd3, 4'b0100};
      tv[8]  = '{2'b10, 2'd0, 4'b0010}; tv[9]  = '{2'b10, 2'd1, 4'b1110};
      tv[10] = '{2'b10, 2'd2, 4'b1100}; tv[11] = '{2'b10, 2'd3, 4'b1000};
      tv[12] = '{2'b11, 2'd0, 4'b0011}; tv[13] = '{2'b11, 2'd1, 4'b1111};
      tv[14] = '{2'b11, 2'd2, 4'b1110}; tv[15] = '{2'b11, 2'd3, 4'b1100};

      // reset state
      rst = 1'b1;
      drive(1'b0, '0, 2'd0, 1'b0);
      step();
      step();
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out", 32'(bus.out), 0);
      rst = 1'b0;
      #1 chk("rel_in_ready", 32'(bus.in_ready), 1);
      @(negedge clk);

      // table: push one, check one-cycle latency, then drain
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, tv[i].in, tv[i].mode, 1'b0);
         step();
         chk($sformatf("tbl%0d_out", i), 32'(bus.out), 32'(tv[i].exp));
         chk($sformatf("tbl%0d_vld", i), 32'(bus.out_valid), 1);
         drive(1'b0, '0, 2'd0, 1'b1);
         step();
         chk($sformatf("tbl%0d_cnt", i), 32'(bus.count), 0);
      end

      // fill to two, third push refused, then drain in order
      drive(1'b1, 2'b01, 2'd1, 1'b0); step();
      drive(1'b1, 2'b10, 2'd0, 1'b0); step();
      chk("full_count", 32'(bus.count), 2);
      chk("full_in_ready", 32'(bus.in_ready), 0);
      drive(1'b1, 2'b11, 2'd3, 1'b0); step();
      chk("full_hold_count", 32'(bus.count), 2);
      chk("full_hold_out", 32'(bus.out), 32'h1);
      drive(1'b0, '0, 2'd0, 1'b1); step();
      chk("drain_b", 32'(bus.out), 32'h2);
      chk("drain_b_cnt", 32'(bus.count), 1);
      step();
      chk("drain_cnt", 32'(bus.count), 0);
      chk("drain_vld", 32'(bus.out_valid), 0);

      // push and pop in the same edge with one held
      drive(1'b1, 2'b01, 2'd2, 1'b0); step();
      chk("pp_cnt1", 32'(bus.count), 1);
      drive(1'b1, 2'b10, 2'd2, 1'b1); step();
      chk("pp_cnt", 32'(bus.count), 1);
      chk("pp_out", 32'(bus.out), 32'hC);
      drive(1'b0, '0, 2'd0, 1'b1); step();
      chk("pp_drain", 32'(bus.count), 0);

      // reset while full discards everything and drops the push
      drive(1'b1, 2'b01, 2'd0, 1'b0); step();
      drive(1'b1, 2'b11, 2'd1, 1'b0); step();
      chk("mr_full", 32'(bus.count), 2);
      rst = 1'b1;
      drive(1'b1, 2'b11, 2'd3, 1'b1); step();
      chk("mr_vld", 32'(bus.out_valid), 0);
      chk("mr_cnt", 32'(bus.count), 0);
      chk("mr_out", 32'(bus.out), 0);
      chk("mr_in_ready", 32'(bus.in_ready), 0);
      rst = 1'b0;
      drive(1'b1, 2'b10, 2'd1, 1'b0); step();
      chk("mr_next_out", 32'(bus.out), 32'hE);
      chk("mr_next_vld", 32'(bus.out_valid), 1);
      drive(1'b0, '0, 2'd0, 1'b1); step();
      chk("mr_drain", 32'(bus.count), 0);

      // random traffic against a queue model
      stalled  = 1'b0;
      prev_out = '0;
      for (int c = 0; c < 1000; c++) begin
         chk("rnd_vld", 32'(bus.out_valid), 32'(q.size() != 0));
         chk("rnd_cnt", 32'(bus.count), 32'(q.size()));
         chk("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() != 2));
         if (q.size() != 0) chk("rnd_out", 32'(bus.out), 32'(q[0]));
         if (stalled) chk("rnd_stall", 32'(bus.out), 32'(prev_out));
         ivld  = ($urandom_range(0, 3) != 0);
         ordy  = ($urandom_range(0, 2) != 0);
         rin   = IN'($urandom);
         rmode = 2'($urandom);
         drive(ivld, rin, rmode, ordy);
         push     = ivld && (q.size() < 2);
         pop      = (q.size() != 0) && ordy;
         exp_v    = model(32'(rin), 32'(rmode));
         stalled  = (q.size() != 0) && !ordy;
         prev_out = bus.out;
         @(posedge clk);
         if (pop) void'(q.pop_front());
         if (push) q.push_back(exp_v);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sign_ext_pipe.md
SIGN_EXT_PIPE -- requirements
Module: sign_ext_pipe

Interface
REQ-001 The parameter IN_SIZE SHALL default to 16 and give the input immediate width; legal range is 1 to OUT_SIZE.
REQ-002 The parameter OUT_SIZE SHALL default to 32 and give the extended output width.
REQ-003 The parameter SHAMT SHALL default to 2 and give the left-shift amount for mode 2; legal range is 0 to OUT_SIZE-1.
REQ-004 The port clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-005 The port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-006 The port in SHALL be an input, IN_SIZE bits wide: the raw immediate.
REQ-007 The port mode SHALL be an input, 2 bits wide: the extension mode, sampled with in.
REQ-008 The port in_valid SHALL be an input, 1 bit wide: the producer presents in/mode.
REQ-009 The port in_ready SHALL be an output, 1 bit wide: the block accepts this cycle.
REQ-010 The port out SHALL be an output, OUT_SIZE bits wide: the extended result at the FIFO head.
REQ-011 The port out_valid SHALL be an output, 1 bit wide: out holds a valid result.
REQ-012 The port out_ready SHALL be an input, 1 bit wide: the consumer takes out this cycle.
REQ-013 The port count SHALL be an output, 2 bits wide: the number of results held (0 to 2).

Function
REQ-014 Mode 0 (zero-extend) SHALL produce out = {zeros, in}.
REQ-015 Mode 1 (sign-extend) SHALL produce out = {(OUT_SIZE-IN_SIZE) copies of in[IN_SIZE-1], in}.
REQ-016 Mode 2 (branch offset) SHALL sign-extend as in mode 1, then shift left by SHAMT, inserting zeros and discarding bits shifted out above OUT_SIZE-1.
REQ-017 Mode 3 (upper) SHALL place in at out[OUT_SIZE-1:OUT_SIZE-IN_SIZE] and zero all lower bits.
REQ-018 When IN_SIZE equals OUT_SIZE, modes 0 and 1 SHALL pass in through unchanged.
REQ-019 A push SHALL occur on any rising edge where in_valid and in_ready are both 1; the extension result is computed combinationally and written into a 2-entry FIFO.
REQ-020 A pop SHALL occur on any rising edge where out_valid and out_ready are both 1.
REQ-021 Latency SHALL be one cycle: a result pushed at edge N is visible on out with out_valid=1 after edge N, provided the FIFO was empty.
REQ-022 out_valid SHALL equal (count != 0), and out SHALL always show the oldest entry.
REQ-023 in_ready SHALL equal (!rst && count != 2), with no combinational path from out_ready; when full, a same-cycle pop does not enable a push.
REQ-024 On a push and pop in the same edge with count=1, count SHALL stay 1 and out SHALL take the newly pushed value.
REQ-025 Results SHALL leave in strict push order, with no loss or duplication.
REQ-026 While out_valid=1 and out_ready=0, out and count SHALL hold stable.
REQ-027 When in_valid=0 or in_ready=0, in and mode SHALL be ignored.
REQ-028 The FIFO SHALL use a 1-bit read pointer and a 1-bit write pointer that wrap from 1 to 0, plus a 2-bit count register.

Reset
REQ-029 When rst=1 at a rising edge, count, both pointers, out and out_valid SHALL all become 0; in_ready is 0 while rst=1 and becomes 1 in the first cycle after rst is released.
REQ-030 A reset asserted mid-operation SHALL discard all stored entries, and no pop SHALL be reported in that cycle.
REQ-031 A push attempted during reset SHALL be dropped.

Verification
REQ-032 Scenario (IN_SIZE=2, OUT_SIZE=4, SHAMT=1), mode 1: in=01 -> out=0001; in=10 -> out=1110; each with out_valid one cycle after the push.
REQ-033 Scenario (same parameters), in=10 in modes 0, 2 and 3 -> out=0010, 1100 and 1000 respectively.
REQ-034 Scenario: three back-to-back pushes (A, B, C) with out_ready=0 -> count=2 and in_ready=0 after the second push, and C is not accepted; after raising out_ready, A then B are delivered, then count=0.
REQ-035 Scenario: with count=1 (A held), push B and pop A in the same edge -> count=1 and out=B.
REQ-036 Scenario: with count=2, assert rst for one cycle -> out_valid=0, count=0, out=0; the next push appears on out after one cycle.
REQ-037 Scenario: random in/mode/in_valid/out_ready traffic over 1000 cycles, checked against a reference model -> output sequence matches in order, and out is stable whenever it is stalled.
